// File: rtl/apb_uart.sv
// rtl/apb_uart.sv - APB3 UART: register file, TX/RX FIFOs, 8N1 serial engines, DMA requests
//
// Optional feature macro: APB_UART_DMA_EN (enables CTRL[3:2] and the dma_* request outputs)
//
// Ports:
//   PCLK, PRESETn              clock (posedge) and asynchronous active-low reset
//   PADDR, PSELx, PENABLE,     APB3 slave request (4-bit address, 8-bit data)
//   PWRITE, PWDATA
//   PRDATA, PREADY, PSLVERR    APB3 slave response (zero wait state)
//   rx, tx                     serial pads, idle high
//   rx_ready_out               RX FIFO holds data
//   dma_tx_req, dma_rx_req     DMA service requests for the TX / RX FIFOs

module apb_uart #(
   parameter int FIFO_DEPTH  = 4,
   parameter int DEFAULT_DIV = 16
) (
   input  logic       PCLK,
   input  logic       PRESETn,
   input  logic [3:0] PADDR,
   input  logic       PSELx,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR,
   input  logic       rx,
   output logic       tx,
   output logic       rx_ready_out,
   output logic       dma_tx_req,
   output logic       dma_rx_req
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

`ifdef APB_UART_DMA_EN
   localparam logic [3:0] CTRL_MASK = 4'hF;
`else
   localparam logic [3:0] CTRL_MASK = 4'h3;
`endif

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // APB decode
   logic access, wr, rd;
   assign access = PSELx & PENABLE;
   assign wr     = access & PWRITE;
   assign rd     = access & ~PWRITE;
   assign PREADY = 1'b1;

   // Registers
   logic [3:0]  ctrl;
   logic [15:0] baud;
   logic [15:0] eff_div;
   logic        overrun, frame_err;

   // Divisors below 2 would leave no room for a mid-bit sample point
   assign eff_div = (baud < 16'd2) ? 16'd2 : baud;

   // TX FIFO
   logic [7:0]    tx_mem [FIFO_DEPTH];
   logic [AW-1:0] tx_wptr, tx_rptr;
   logic          tx_full, tx_empty, tx_push, tx_pop;

   // RX FIFO
   logic [7:0]    rx_mem [FIFO_DEPTH];
   logic [AW-1:0] rx_wptr, rx_rptr;
   logic          rx_full, rx_empty, rx_push, rx_pop;

   assign tx_empty = (tx_wptr == tx_rptr) & ~tx_full;
   assign rx_empty = (rx_wptr == rx_rptr) & ~rx_full;
   assign tx_push  = wr & (PADDR == 4'h0) & ~tx_full;
   assign rx_pop   = rd & (PADDR == 4'h0) & ~rx_empty;

   // TX engine
   state_t      tx_state, tx_state_n;
   logic [15:0] tx_cnt, tx_div;
   logic [2:0]  tx_idx;
   logic [7:0]  tx_shift;
   logic        tx_bit_end, tx_busy;

   // RX engine
   state_t      rx_state, rx_state_n;
   logic [15:0] rx_cnt, rx_div;
   logic [2:0]  rx_idx;
   logic [7:0]  rx_shift;
   logic        rx_s1, rx_s2, rx_s3, rx_fall;
   logic        rx_bit_end, rx_half, rx_stop_smp;

   logic [7:0] status;
   assign tx_busy = (tx_state != S_IDLE);
   assign status  = {1'b0, tx_busy, frame_err, overrun, ~rx_empty, rx_full, tx_empty, tx_full};

   // Read mux and error response, driven only during the access phase
   always_comb begin
      PRDATA  = 8'h00;
      PSLVERR = 1'b0;
      if (access) begin
         case (PADDR)
            4'h0: begin
               if (PWRITE)        PSLVERR = tx_full;
               else if (rx_empty) PSLVERR = 1'b1;
               else               PRDATA  = rx_mem[rx_rptr];
            end
            4'h1: if (!PWRITE) PRDATA = status;
            4'h2: if (!PWRITE) PRDATA = {4'h0, ctrl};
            4'h3: if (!PWRITE) PRDATA = baud[7:0];
            4'h4: if (!PWRITE) PRDATA = baud[15:8];
            default: PSLVERR = 1'b1;
         endcase
      end
   end

   // Register writes and sticky flags; a new error event wins over a same-cycle clear
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ctrl      <= 4'h3;
         baud      <= 16'(DEFAULT_DIV);
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (wr && PADDR == 4'h2) ctrl        <= PWDATA[3:0] & CTRL_MASK;
         if (wr && PADDR == 4'h3) baud[7:0]   <= PWDATA;
         if (wr && PADDR == 4'h4) baud[15:8]  <= PWDATA;
         overrun   <= (overrun & ~(wr && PADDR == 4'h1 && PWDATA[4]))
                      | (rx_stop_smp & rx_s2 & rx_full);
         frame_err <= (frame_err & ~(wr && PADDR == 4'h1 && PWDATA[5]))
                      | (rx_stop_smp & ~rx_s2);
      end
   end

   // FIFO storage (no reset needed; validity is tracked by the pointers)
   always_ff @(posedge PCLK) begin
      if (tx_push) tx_mem[tx_wptr] <= PWDATA;
      if (rx_push) rx_mem[rx_wptr] <= rx_shift;
   end

   // FIFO pointers: full is set only when a lone push closes the gap, cleared by a lone pop
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         tx_full <= 1'b0;
         rx_wptr <= '0;
         rx_rptr <= '0;
         rx_full <= 1'b0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
         if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
         if (tx_push && !tx_pop && (tx_wptr + PTR_ONE) == tx_rptr) tx_full <= 1'b1;
         else if (tx_pop && !tx_push)                              tx_full <= 1'b0;
         if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
         if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
         if (rx_push && !rx_pop && (rx_wptr + PTR_ONE) == rx_rptr) rx_full <= 1'b1;
         else if (rx_pop && !rx_push)                              rx_full <= 1'b0;
      end
   end

   // ---------------- Transmitter ----------------
   assign tx_bit_end = (tx_cnt == tx_div - 16'd1);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) tx_state <= S_IDLE;
      else          tx_state <= tx_state_n;
   end

   // A frame may start straight out of STOP so consecutive bytes have no idle gap
   always_comb begin
      tx_state_n = tx_state;
      tx_pop     = 1'b0;
      case (tx_state)
         S_IDLE: begin
            if (ctrl[0] && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_state_n = S_START;
            end
         end
         S_START: if (tx_bit_end) tx_state_n = S_DATA;
         S_DATA:  if (tx_bit_end && tx_idx == 3'd7) tx_state_n = S_STOP;
         S_STOP: begin
            if (tx_bit_end) begin
               if (ctrl[0] && !tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_state_n = S_START;
               end else begin
                  tx_state_n = S_IDLE;
               end
            end
         end
         default: tx_state_n = S_IDLE;
      endcase
   end

   // Divisor is captured at frame start so BAUD writes never disturb a frame in flight
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tx_cnt   <= '0;
         tx_div   <= 16'd2;
         tx_idx   <= '0;
         tx_shift <= '0;
      end else if (tx_pop) begin
         tx_shift <= tx_mem[tx_rptr];
         tx_div   <= eff_div;
         tx_cnt   <= '0;
         tx_idx   <= '0;
      end else if (tx_state != S_IDLE) begin
         if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_state == S_DATA) begin
               tx_shift <= {1'b0, tx_shift[7:1]};
               tx_idx   <= tx_idx + 3'd1;
            end
         end else begin
            tx_cnt <= tx_cnt + 16'd1;
         end
      end
   end

   assign tx = (tx_state == S_START) ? 1'b0 :
               (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;

   // ---------------- Receiver ----------------
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   assign rx_fall     = rx_s3 & ~rx_s2;
   assign rx_bit_end  = (rx_cnt == rx_div - 16'd1);
   assign rx_half     = (rx_cnt == (rx_div >> 1) - 16'd1);
   assign rx_stop_smp = (rx_state == S_STOP) & rx_bit_end;
   assign rx_push     = rx_stop_smp & rx_s2 & ~rx_full;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) rx_state <= S_IDLE;
      else          rx_state <= rx_state_n;
   end

   always_comb begin
      rx_state_n = rx_state;
      case (rx_state)
         S_IDLE:  if (ctrl[1] && rx_fall) rx_state_n = S_START;
         S_START: if (rx_half) rx_state_n = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (rx_bit_end && rx_idx == 3'd7) rx_state_n = S_STOP;
         S_STOP:  if (rx_bit_end) rx_state_n = S_IDLE;
         default: rx_state_n = S_IDLE;
      endcase
   end

   // While idle the divisor tracks BAUD, so it is current when a start edge arrives
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rx_cnt   <= '0;
         rx_div   <= 16'd2;
         rx_idx   <= '0;
         rx_shift <= '0;
      end else if (rx_state == S_IDLE) begin
         rx_cnt <= '0;
         rx_idx <= '0;
         rx_div <= eff_div;
      end else if (rx_state == S_START) begin
         rx_cnt <= rx_half ? 16'd0 : rx_cnt + 16'd1;
      end else if (rx_bit_end) begin
         rx_cnt <= '0;
         if (rx_state == S_DATA) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_idx   <= rx_idx + 3'd1;
         end
      end else begin
         rx_cnt <= rx_cnt + 16'd1;
      end
   end

   assign rx_ready_out = ~rx_empty;

`ifdef APB_UART_DMA_EN
   assign dma_tx_req = ctrl[2] & ~tx_full;
   assign dma_rx_req = ctrl[3] & ~rx_empty;
`else
   assign dma_tx_req = 1'b0;
   assign dma_rx_req = 1'b0;
`endif

endmodule

// File: tb/tb_apb_uart.sv
// tb/tb_apb_uart.sv - self-checking bench for apb_uart with a frame-level TX model

module tb_apb_uart;

   localparam int DEPTH = 4;
   localparam int DDIV  = 16;
`ifdef APB_UART_DMA_EN
   localparam logic [7:0] CMASK = 8'h0F;
`else
   localparam logic [7:0] CMASK = 8'h03;
`endif

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic [3:0] PADDR = 4'h0;
   logic       PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [7:0] PWDATA = 8'h00;
   logic [7:0] PRDATA;
   logic       PREADY, PSLVERR;
   logic       rx, tx, rx_ready_out, dma_tx_req, dma_rx_req;
   logic       loop_en = 1'b0, rx_drv = 1'b1;

   assign rx = loop_en ? tx : rx_drv;

   apb_uart #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .rx(rx), .tx(tx), .rx_ready_out(rx_ready_out),
      .dma_tx_req(dma_tx_req), .dma_rx_req(dma_rx_req)
   );

   always #5 PCLK = ~PCLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit check_on = 1'b0;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level transmitter model: FIFO as a queue, a frame as 10 bit slots of m_div cycles
   logic [7:0]  mq[$];
   bit          m_busy;
   int          m_cyc, m_div;
   logic [7:0]  m_byte;
   logic [7:0]  m_ctrl;
   logic [15:0] m_baud;
   bit          m_accept;

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         mq.delete();
         m_busy = 1'b0;
         m_cyc  = 0;
         m_div  = 2;
         m_ctrl = 8'h03;
         m_baud = 16'(DDIV);
      end else begin
         m_accept = PSELx && PENABLE && PWRITE && PADDR == 4'h0 && mq.size() < DEPTH;
         if (m_busy) begin
            m_cyc++;
            if (m_cyc == 10 * m_div) m_busy = 1'b0;
         end
         if (!m_busy && m_ctrl[0] && mq.size() > 0) begin
            m_byte = mq.pop_front();
            m_busy = 1'b1;
            m_cyc  = 0;
            m_div  = (m_baud < 16'd2) ? 2 : int'(m_baud);
         end
         if (m_accept) mq.push_back(PWDATA);
         if (PSELx && PENABLE && PWRITE) begin
            case (PADDR)
               4'h2: m_ctrl = PWDATA & CMASK;
               4'h3: m_baud[7:0]  = PWDATA;
               4'h4: m_baud[15:8] = PWDATA;
               default: ;
            endcase
         end
      end
   end

   function automatic logic exp_tx();
      int k;
      if (!m_busy) return 1'b1;
      k = m_cyc / m_div;
      if (k == 0) return 1'b0;
      if (k >= 9) return 1'b1;
      return m_byte[k-1];
   endfunction

   // Per-cycle compare against the model, sampled well away from the clock edge
   always @(negedge PCLK) begin
      #3;
      if (PRESETn && check_on) begin
         check("tx_line", tx, exp_tx());
         check("pready", PREADY, 1'b1);
         check("dma_tx_req", dma_tx_req, m_ctrl[2] && (mq.size() < DEPTH));
         if (!(PSELx && PENABLE)) begin
            check("prdata_idle", PRDATA, 8'h00);
            check("pslverr_idle", PSLVERR, 1'b0);
         end
      end
   end

   task automatic apb_xfer(input logic [3:0] a, input logic w, input logic [7:0] d,
                           output logic [7:0] rd, output logic err);
      @(negedge PCLK);
      PSELx = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
      @(negedge PCLK);
      PENABLE = 1'b1;
      #1;
      rd  = PRDATA;
      err = PSLVERR;
      @(negedge PCLK);
      PSELx = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wr_chk(input string name, input logic [3:0] a, input logic [7:0] d,
                         input logic exp_err);
      logic [7:0] rd;
      logic err;
      apb_xfer(a, 1'b1, d, rd, err);
      check({name, "_err"}, err, exp_err);
   endtask

   task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp_d,
                         input logic exp_err);
      logic [7:0] rd;
      logic err;
      apb_xfer(a, 1'b0, 8'h00, rd, err);
      check(name, rd, exp_d);
      check({name, "_err"}, err, exp_err);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge PCLK);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge PCLK);
         rx_drv = fr[i];
         wait_cycles(DDIV - 1);
      end
      @(negedge PCLK);
      rx_drv = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] a5_bits;
      int w;

      // Reset values while reset is held
      #12;
      check("rst_tx", tx, 1'b1);
      check("rst_pready", PREADY, 1'b1);
      check("rst_prdata", PRDATA, 8'h00);
      check("rst_pslverr", PSLVERR, 1'b0);
      check("rst_rx_ready", rx_ready_out, 1'b0);
      check("rst_dma", {dma_tx_req, dma_rx_req}, 2'b00);
      wait_cycles(3);
      PRESETn = 1'b1;
      check_on = 1'b1;

      rd_chk("rst_status", 4'h1, 8'h02, 1'b0);
      rd_chk("rst_ctrl", 4'h2, 8'h03, 1'b0);
      rd_chk("rst_baud_lo", 4'h3, 8'(DDIV), 1'b0);
      rd_chk("rst_baud_hi", 4'h4, 8'h00, 1'b0);

      // 0xA5 frame, pinned against a literal bit pattern at mid-bit points
      a5_bits = {1'b1, 8'hA5, 1'b0};
      wr_chk("wr_a5", 4'h0, 8'hA5, 1'b0);
      w = cyc;
      rd_chk("status_busy", 4'h1, 8'h42, 1'b0);
      for (int k = 0; k < 10; k++) begin
         wait_until(w + 9 + DDIV * k);
         #1;
         check($sformatf("a5_bit%0d", k), tx, a5_bits[k]);
      end
      wait_until(w + 1 + 10 * DDIV + 2);
      rd_chk("status_done", 4'h1, 8'h02, 1'b0);

      // Loopback receive
      loop_en = 1'b1;
      wr_chk("wr_3c", 4'h0, 8'h3C, 1'b0);
      wait_cycles(175);
      check("rx_ready_set", rx_ready_out, 1'b1);
      rd_chk("rd_3c", 4'h0, 8'h3C, 1'b0);
      rd_chk("rd_empty", 4'h0, 8'h00, 1'b1);
      check("rx_ready_clr", rx_ready_out, 1'b0);

      // Divisor boundary: 1 behaves as 2, and an odd divisor
      wr_chk("baud_1", 4'h3, 8'h01, 1'b0);
      wr_chk("wr_5a", 4'h0, 8'h5A, 1'b0);
      wait_cycles(40);
      rd_chk("rd_5a", 4'h0, 8'h5A, 1'b0);
      wr_chk("baud_5", 4'h3, 8'h05, 1'b0);
      wr_chk("wr_c3", 4'h0, 8'hC3, 1'b0);
      wait_cycles(70);
      rd_chk("rd_c3", 4'h0, 8'hC3, 1'b0);
      wr_chk("baud_hi", 4'h4, 8'h01, 1'b0);
      rd_chk("rd_baud_hi", 4'h4, 8'h01, 1'b0);
      wr_chk("baud_hi0", 4'h4, 8'h00, 1'b0);
      wr_chk("baud_16", 4'h3, 8'(DDIV), 1'b0);

      // Overfill TX with transmitter disabled
      loop_en = 1'b0;
      wr_chk("ctrl_02", 4'h2, 8'h02, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++)
         wr_chk($sformatf("fill%0d", i), 4'h0, 8'(8'h11 + i), (i >= DEPTH));
      rd_chk("status_full", 4'h1, 8'h01, 1'b0);
      wr_chk("ctrl_03", 4'h2, 8'h03, 1'b0);
      wait_cycles(20);
      wr_chk("ctrl_off_mid", 4'h2, 8'h02, 1'b0);
      wait_cycles(200);
      rd_chk("status_paused", 4'h1, 8'h00, 1'b0);
      wr_chk("ctrl_on", 4'h2, 8'h03, 1'b0);
      wait_cycles(3 * 10 * DDIV + 10);
      rd_chk("status_drained", 4'h1, 8'h02, 1'b0);

      // Framing error, then a good externally driven frame
      send_rx(8'h55, 1'b0);
      wait_cycles(20);
      rd_chk("status_ferr", 4'h1, 8'h22, 1'b0);
      check("ferr_no_data", rx_ready_out, 1'b0);
      wr_chk("w1c_ferr", 4'h1, 8'h20, 1'b0);
      rd_chk("status_ferr_clr", 4'h1, 8'h02, 1'b0);
      send_rx(8'h96, 1'b1);
      wait_cycles(5);
      rd_chk("rd_96", 4'h0, 8'h96, 1'b0);

      // Overrun: five frames into a four-entry RX FIFO
      loop_en = 1'b1;
      for (int i = 0; i < 5; i++)
         wr_chk($sformatf("ovr_wr%0d", i), 4'h0, 8'(i + 1), 1'b0);
      wait_cycles(5 * 10 * DDIV + 50);
      rd_chk("status_ovr", 4'h1, 8'h1E, 1'b0);
      for (int i = 0; i < DEPTH; i++)
         rd_chk($sformatf("ovr_rd%0d", i), 4'h0, 8'(i + 1), 1'b0);
      rd_chk("status_ovr2", 4'h1, 8'h12, 1'b0);
      wr_chk("w1c_all", 4'h1, 8'hFF, 1'b0);
      rd_chk("status_ovr_clr", 4'h1, 8'h02, 1'b0);

      // DMA requests
      wr_chk("ctrl_0f", 4'h2, 8'h0F, 1'b0);
      rd_chk("rd_ctrl_0f", 4'h2, CMASK, 1'b0);
      wr_chk("wr_77", 4'h0, 8'h77, 1'b0);
      wait_cycles(175);
      check("dma_rx_req_set", dma_rx_req, CMASK[3]);
      rd_chk("rd_77", 4'h0, 8'h77, 1'b0);
      check("dma_rx_req_clr", dma_rx_req, 1'b0);
      wr_chk("ctrl_restore", 4'h2, 8'h03, 1'b0);

      // Unmapped addresses
      rd_chk("rd_addr7", 4'h7, 8'h00, 1'b1);
      wr_chk("wr_addr7", 4'h7, 8'hFF, 1'b1);
      rd_chk("rd_addr5", 4'h5, 8'h00, 1'b1);

      // Asynchronous reset in the middle of a frame
      loop_en = 1'b0;
      wr_chk("wr_00", 4'h0, 8'h00, 1'b0);
      wait_cycles(50);
      check("mid_frame_low", tx, 1'b0);
      @(posedge PCLK);
      #2;
      PRESETn = 1'b0;
      #1;
      check("async_rst_tx", tx, 1'b1);
      wait_cycles(3);
      PRESETn = 1'b1;
      rd_chk("post_rst_status", 4'h1, 8'h02, 1'b0);
      rd_chk("post_rst_ctrl", 4'h2, 8'h03, 1'b0);
      rd_chk("post_rst_baud", 4'h3, 8'(DDIV), 1'b0);
      wait_cycles(5);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
